// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: address/control sequencer for an in-place radix-2 DIT FFT
// Ports: clk, rst_n (async active-low); start -> busy, done.
//   rd_addr_a/b, tw_addr: RAM/ROM read addresses, data returns one cycle later on rd_data_a/b, tw_data.
//   bf_A/B/W: operands to an external butterfly; bf_sum/bf_diff: its results.
//   wr_en, wr_addr_a/b, wr_data_a/b: write-back of sum (port a) and diff (port b).
module fft_stage_sequencer #(
  parameter int WIDTH = 36,
  parameter int N     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [$clog2(N)-1:0] rd_addr_a,
  output logic [$clog2(N)-1:0] rd_addr_b,
  input  logic [WIDTH-1:0]     rd_data_a,
  input  logic [WIDTH-1:0]     rd_data_b,
  output logic [$clog2(N)-2:0] tw_addr,
  input  logic [WIDTH-1:0]     tw_data,
  output logic [WIDTH-1:0]     bf_A,
  output logic [WIDTH-1:0]     bf_B,
  output logic [WIDTH-1:0]     bf_W,
  input  logic [WIDTH-1:0]     bf_sum,
  input  logic [WIDTH-1:0]     bf_diff,
  output logic                 wr_en,
  output logic [$clog2(N)-1:0] wr_addr_a,
  output logic [$clog2(N)-1:0] wr_addr_b,
  output logic [WIDTH-1:0]     wr_data_a,
  output logic [WIDTH-1:0]     wr_data_b
);
  localparam int LOG2N = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t           state;
  logic [LOG2N-1:0] s;
  logic [LOG2N-2:0] j;
  logic             dc;
  logic             iss_v;
  logic             op_v;
  logic [LOG2N-1:0] op_a;
  logic [LOG2N-1:0] op_b;
  logic [LOG2N-2:0] mask;
  logic [LOG2N-2:0] pos;
  logic [LOG2N-1:0] ia;
  logic [LOG2N-1:0] half;
  logic [LOG2N-2:0] tw;
  // Address a is j with a zero bit inserted at position s; b sets that bit.
  always_comb begin
    mask = ~({(LOG2N-1){1'b1}} << s);
    pos  = j & mask;
    ia   = (({1'b0, j} >> s) << (s + 1'b1)) | {1'b0, pos};
    half = {{(LOG2N-1){1'b0}}, 1'b1} << s;
    tw   = pos << (LOG2N - 1 - s);
  end
  assign bf_A = rd_data_a;
  assign bf_B = rd_data_b;
  assign bf_W = tw_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s         <= '0;
      j         <= '0;
      dc        <= 1'b0;
      iss_v     <= 1'b0;
      op_v      <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
      wr_en     <= 1'b0;
      wr_addr_a <= '0;
      wr_addr_b <= '0;
      wr_data_a <= '0;
      wr_data_b <= '0;
    end else begin
      iss_v     <= state == RUN;
      rd_addr_a <= state == RUN ? ia : '0;
      rd_addr_b <= state == RUN ? ia | half : '0;
      tw_addr   <= state == RUN ? tw : '0;
      op_v      <= iss_v;
      op_a      <= rd_addr_a;
      op_b      <= rd_addr_b;
      wr_en     <= op_v;
      wr_addr_a <= op_v ? op_a : '0;
      wr_addr_b <= op_v ? op_b : '0;
      wr_data_a <= op_v ? bf_sum : '0;
      wr_data_b <= op_v ? bf_diff : '0;
      busy      <= state == RUN || state == DRAIN;
      done      <= state == DONE;
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          s     <= '0;
          j     <= '0;
        end
        RUN: begin
          j <= j + 1'b1;
          if (&j) begin
            state <= DRAIN;
            dc    <= 1'b0;
          end
        end
        // Two drain cycles let the last write of a stage land before the next stage reads.
        DRAIN: begin
          dc <= 1'b1;
          if (dc) begin
            if (s == LOG2N'(LOG2N - 1)) state <= DONE;
            else begin
              s     <= s + 1'b1;
              state <= RUN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: random and directed checks of the FFT sequencer against a reference FFT
module tb_fft_stage_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  function automatic logic [35:0] twv(input int n, input int k);
    int re, im;
    re = int'($cos(6.283185307179586 * k / n) * 131072.0);
    im = int'(-$sin(6.283185307179586 * k / n) * 131072.0);
    if (re > 131071) re = 131071;
    if (im > 131071) im = 131071;
    return {re[17:0], im[17:0]};
  endfunction
  function automatic logic [71:0] bfly(input logic [35:0] a, input logic [35:0] b, input logic [35:0] w);
    longint ar, ai, br, bi, wr, wi, pr, pim;
    logic [17:0] sr, si, dr, di;
    ar = longint'($signed(a[35:18]));
    ai = longint'($signed(a[17:0]));
    br = longint'($signed(b[35:18]));
    bi = longint'($signed(b[17:0]));
    wr = longint'($signed(w[35:18]));
    wi = longint'($signed(w[17:0]));
    pr  = (br * wr - bi * wi) >>> 17;
    pim = (br * wi + bi * wr) >>> 17;
    sr = 18'(ar + pr);
    si = 18'(ai + pim);
    dr = 18'(ar - pr);
    di = 18'(ai - pim);
    return {sr, si, dr, di};
  endfunction
  // k-th address (ascending) whose bit s is clear
  function automatic int pair_a(input int s, input int k);
    int c = 0;
    for (int a = 0; a < 64; a++)
      if (((a >> s) & 1) == 0) begin
        if (c == k) return a;
        c++;
      end
    return -1;
  endfunction
  logic start8 = 1'b0, busy8, done8, we8;
  logic [2:0] ra8, rb8, wa8, wb8;
  logic [1:0] ta8;
  logic [35:0] rda8, rdb8, tw8, a8, b8, w8, sum8, diff8, wda8, wdb8;
  logic start32 = 1'b0, busy32, done32, we32;
  logic [4:0] ra32, rb32, wa32, wb32;
  logic [3:0] ta32;
  logic [35:0] rda32, rdb32, tw32, a32, b32, w32, sum32, diff32, wda32, wdb32;
  assign {sum8, diff8} = bfly(a8, b8, w8);
  assign {sum32, diff32} = bfly(a32, b32, w32);
  fft_stage_sequencer #(.WIDTH(36), .N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .busy(busy8), .done(done8),
    .rd_addr_a(ra8), .rd_addr_b(rb8), .rd_data_a(rda8), .rd_data_b(rdb8),
    .tw_addr(ta8), .tw_data(tw8), .bf_A(a8), .bf_B(b8), .bf_W(w8),
    .bf_sum(sum8), .bf_diff(diff8), .wr_en(we8), .wr_addr_a(wa8), .wr_addr_b(wb8),
    .wr_data_a(wda8), .wr_data_b(wdb8));
  fft_stage_sequencer #(.WIDTH(36), .N(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .busy(busy32), .done(done32),
    .rd_addr_a(ra32), .rd_addr_b(rb32), .rd_data_a(rda32), .rd_data_b(rdb32),
    .tw_addr(ta32), .tw_data(tw32), .bf_A(a32), .bf_B(b32), .bf_W(w32),
    .bf_sum(sum32), .bf_diff(diff32), .wr_en(we32), .wr_addr_a(wa32), .wr_addr_b(wb32),
    .wr_data_a(wda32), .wr_data_b(wdb32));
  logic [35:0] mem8 [8];
  logic [35:0] mem32 [32];
  logic ld = 1'b0, ld_sel = 1'b0;
  logic [4:0] ld_a = '0;
  logic [35:0] ld_d = '0;
  always @(posedge clk) begin
    if (ld && !ld_sel) mem8[ld_a[2:0]] <= ld_d;
    else if (we8) begin
      mem8[wa8] <= wda8;
      mem8[wb8] <= wdb8;
    end
    if (ld && ld_sel) mem32[ld_a] <= ld_d;
    else if (we32) begin
      mem32[wa32] <= wda32;
      mem32[wb32] <= wdb32;
    end
    rda8  <= mem8[ra8];
    rdb8  <= mem8[rb8];
    tw8   <= twv(8, int'(ta8));
    rda32 <= mem32[ra32];
    rdb32 <= mem32[rb32];
    tw32  <= twv(32, int'(ta32));
  end
  logic [35:0] in_d [32];
  logic [35:0] exp_d [32];
  task automatic load(input int n, input bit impulse);
    for (int i = 0; i < n; i++) begin
      in_d[i] = impulse ? (i == 0 ? 36'h200000000 : 36'h0) : 36'({$urandom, $urandom});
      ld = 1'b1;
      ld_sel = n == 32;
      ld_a = 5'(i);
      ld_d = in_d[i];
      @(posedge clk); #1;
    end
    ld = 1'b0;
  endtask
  task automatic ref_fft(input int n);
    int half;
    for (int i = 0; i < n; i++) exp_d[i] = in_d[i];
    for (int s = 0; (1 << s) < n; s++) begin
      half = 1 << s;
      for (int g = 0; g < n; g += 2 * half)
        for (int k = 0; k < half; k++)
          {exp_d[g+k], exp_d[g+k+half]} = bfly(exp_d[g+k], exp_d[g+k+half], twv(n, k * n / (2 * half)));
    end
  endtask
  // Full N=8 run with per-cycle trace check; optional start noise while busy.
  task automatic run8(input bit noise);
    int nwr = 0;
    int u, si, ki, ea;
    bit iv, wv;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      @(posedge clk); #1;
      u = c - 1; si = u / 6; ki = u % 6;
      iv = si < 3 && ki < 4;
      ea = iv ? pair_a(si, ki) : 0;
      chk("rd_a", 64'(ra8), 64'(ea));
      chk("rd_b", 64'(rb8), iv ? 64'(ea + (1 << si)) : 64'd0);
      chk("tw", 64'(ta8), iv ? 64'((ea % (1 << si)) * (8 / (2 << si))) : 64'd0);
      wv = 0;
      if (c >= 3) begin
        u = c - 3; si = u / 6; ki = u % 6;
        wv = si < 3 && ki < 4;
      end
      chk("wr_en", 64'(we8), 64'(wv));
      if (wv) begin
        ea = pair_a(si, ki);
        chk("wr_a", 64'(wa8), 64'(ea));
        chk("wr_b", 64'(wb8), 64'(ea + (1 << si)));
      end
      chk("busy", 64'(busy8), 64'(c <= 18));
      chk("done", 64'(done8), 64'(c == 19));
      if (we8) nwr++;
      start8 = noise && c <= 18 ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    chk("n_writes", 64'(nwr), 64'd12);
  endtask
  initial begin
    int nw, nb, dc, cyc;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy8), 0);
    chk("rst_done", 64'(done8), 0);
    chk("rst_wr_en", 64'(we8), 0);
    chk("rst_rd_a", 64'(ra8), 0);
    chk("rst_tw", 64'(ta32), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    load(8, 1);
    run8(0);
    for (int i = 0; i < 8; i++) chk($sformatf("impulse[%0d]", i), 64'(mem8[i]), 64'h200000000);
    load(8, 0);
    ref_fft(8);
    run8(1);
    for (int i = 0; i < 8; i++) chk($sformatf("rand8[%0d]", i), 64'(mem8[i]), 64'(exp_d[i]));
    load(8, 0);
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("pre_abort_wr", 64'(we8), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_wr_en", 64'(we8), 0);
    chk("abort_busy", 64'(busy8), 0);
    chk("abort_rd_a", 64'(ra8), 0);
    chk("abort_rd_b", 64'(rb8), 0);
    chk("abort_tw", 64'(ta8), 0);
    chk("abort_wr_a", 64'(wa8), 0);
    chk("abort_wr_d", 64'(wda8), 0);
    nw = 0;
    repeat (3) begin @(posedge clk); #1; nw += int'(we8); end
    rst_n = 1'b1;
    repeat (5) begin @(posedge clk); #1; nw += int'(we8) + int'(busy8); end
    chk("abort_quiet", 64'(nw), 0);
    load(8, 0);
    ref_fft(8);
    run8(0);
    for (int i = 0; i < 8; i++) chk($sformatf("rerun8[%0d]", i), 64'(mem8[i]), 64'(exp_d[i]));
    load(32, 0);
    ref_fft(32);
    start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    cyc = 0; nb = 0; nw = 0; dc = -1;
    while (cyc < 300 && dc < 0) begin
      @(posedge clk); #1;
      cyc++;
      nb += int'(busy32);
      nw += int'(we32);
      if (done32) dc = cyc;
    end
    chk("done32_cycle", 64'(dc), 64'd91);
    chk("busy32_cycles", 64'(nb), 64'd90);
    chk("writes32", 64'(nw), 64'd80);
    for (int i = 0; i < 32; i++) chk($sformatf("rand32[%0d]", i), 64'(mem32[i]), 64'(exp_d[i]));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
